// File: rtl/rsa_bus_master.sv
// Byte-serial register-bus initiator for the exp2_rsa core: writes N/D/C, pulses start,
// waits for a ready rising edge, reads the 32-byte result. Define RSA_MASTER_TIMEOUT_EN for the WAIT_RDY watchdog.
module rsa_bus_master #(
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_load_key,
  input  logic [255:0] cmd_n,
  input  logic [255:0] cmd_d,
  input  logic [255:0] cmd_c,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [255:0] res_data,
  output logic         res_err,
  output logic         bus_we,
  output logic         bus_oe,
  output logic         bus_start,
  output logic [1:0]   bus_reg_sel,
  output logic [4:0]   bus_addr,
  output logic [7:0]   bus_wdata,
  input  logic [7:0]   bus_rdata,
  input  logic         bus_ready
);

  localparam int            CW       = $clog2(32 + RD_LAT + 1);
  localparam logic [CW-1:0] RD_FIRST = CW'(RD_LAT);
  localparam logic [CW-1:0] RD_LAST  = CW'(31 + RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_N, S_WR_D, S_WR_C, S_START, S_WAIT_RDY, S_RD, S_DONE
  } state_t;

  state_t        state;
  logic [255:0]  op_n, op_d, op_c, cur_op;
  logic [CW-1:0] rd_cnt;
  logic [4:0]    rd_byte, next_addr;
  logic          rdy_prev, rdy_rise;

`ifdef RSA_MASTER_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;
  assign res_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign res_err = 1'b0;
`endif

  assign cmd_ready = (state == S_IDLE);
  assign next_addr = bus_addr + 5'd1;
  assign rd_byte   = 5'(rd_cnt - RD_FIRST);
  // rdy_prev tracks bus_ready every cycle, so a level already high during START never counts as an edge
  assign rdy_rise  = bus_ready & ~rdy_prev;

  always_comb begin
    case (bus_reg_sel)
      2'd3:    cur_op = op_n;
      2'd2:    cur_op = op_d;
      default: cur_op = op_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_n        <= '0;
      op_d        <= '0;
      op_c        <= '0;
      rd_cnt      <= '0;
      rdy_prev    <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      bus_we      <= 1'b0;
      bus_oe      <= 1'b0;
      bus_start   <= 1'b0;
      bus_reg_sel <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
`ifdef RSA_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      rdy_prev <= bus_ready;
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_n     <= cmd_n;
          op_d     <= cmd_d;
          op_c     <= cmd_c;
          bus_we   <= 1'b1;
          bus_addr <= '0;
`ifdef RSA_MASTER_TIMEOUT_EN
          err_q    <= 1'b0;
`endif
          if (cmd_load_key) begin
            state       <= S_WR_N;
            bus_reg_sel <= 2'd3;
            bus_wdata   <= cmd_n[7:0];
          end else begin
            state       <= S_WR_C;
            bus_reg_sel <= 2'd1;
            bus_wdata   <= cmd_c[7:0];
          end
        end
        S_WR_N, S_WR_D, S_WR_C: begin
          if (bus_addr != 5'd31) begin
            bus_addr  <= next_addr;
            bus_wdata <= cur_op[{next_addr, 3'b000} +: 8];
          end else begin
            bus_addr <= '0;
            if (state == S_WR_N) begin
              state       <= S_WR_D;
              bus_reg_sel <= 2'd2;
              bus_wdata   <= op_d[7:0];
            end else if (state == S_WR_D) begin
              state       <= S_WR_C;
              bus_reg_sel <= 2'd1;
              bus_wdata   <= op_c[7:0];
            end else begin
              state       <= S_START;
              bus_we      <= 1'b0;
              bus_start   <= 1'b1;
              bus_reg_sel <= '0;
              bus_wdata   <= '0;
            end
          end
        end
        S_START: begin
          state     <= S_WAIT_RDY;
          bus_start <= 1'b0;
`ifdef RSA_MASTER_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        S_WAIT_RDY: begin
          if (rdy_rise) begin
            state    <= S_RD;
            bus_oe   <= 1'b1;
            bus_addr <= '0;
            rd_cnt   <= '0;
          end
`ifdef RSA_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            res_data  <= '0;
            err_q     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        S_RD: begin
          if (rd_cnt >= RD_FIRST) res_data[{rd_byte, 3'b000} +: 8] <= bus_rdata;
          if (rd_cnt == RD_LAST) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            bus_oe    <= 1'b0;
            bus_addr  <= '0;
          end else begin
            rd_cnt <= rd_cnt + CW'(1);
            if (bus_addr != 5'd31) bus_addr <= next_addr;
          end
        end
        S_DONE: if (res_ready) begin
          state     <= S_IDLE;
          res_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_bus_master.sv
// Randomized scoreboard bench for rsa_bus_master with a behavioural exp2_rsa bus model.
`timescale 1ns/1ps
module tb_rsa_bus_master;
  localparam int RD_LAT = 1;
`ifdef RSA_MASTER_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 1 << 20;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_load_key;
  logic [255:0] cmd_n, cmd_d, cmd_c;
  logic         res_valid, res_ready, res_err;
  logic [255:0] res_data;
  logic         bus_we, bus_oe, bus_start;
  logic [1:0]   bus_reg_sel;
  logic [4:0]   bus_addr;
  logic [7:0]   bus_wdata;
  logic [7:0]   bus_rdata = 8'h00;
  logic         bus_ready = 1'b1;

  rsa_bus_master #(.RD_LAT(RD_LAT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load_key(cmd_load_key),
    .cmd_n(cmd_n), .cmd_d(cmd_d), .cmd_c(cmd_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .bus_we(bus_we), .bus_oe(bus_oe), .bus_start(bus_start), .bus_reg_sel(bus_reg_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Stand-in for the core's modular exponentiation: any mixing of all three operands will do.
  function automatic logic [255:0] core_fn(input logic [255:0] c, input logic [255:0] d,
                                           input logic [255:0] n);
    return (c ^ d) + n;
  endfunction

  typedef struct {
    logic [255:0] data;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_key_q[$];

  // ---------------- exp2_rsa bus model ----------------
  logic [255:0] core_reg [4];
  logic [7:0]   rd_next = 8'h00;
  int  wr_cnt = 0;
  bit  prev_start = 1'b0;
  bit  oe_seen = 1'b1;
  int  rdy_mode = 0;
  int  drop_cyc = -1, rise_cyc = -1, exp_done_cyc = -1;

  always @(negedge clk) begin
    if (reset) begin
      wr_cnt     = 0;
      prev_start = 1'b0;
      rd_next    = 8'h00;
      bus_rdata  = 8'h00;
    end else begin
      bus_rdata = rd_next;
      rd_next   = bus_oe ? core_reg[0][{bus_addr, 3'b000} +: 8] : 8'h00;
      if (bus_we) begin
        bus_ready = 1'b1;
        if (exp_key_q.size() == 0) begin
          chk("unexpected_write", 1'b1, 1'b0);
        end else begin
          chk("wr_sel", bus_reg_sel, exp_key_q[0] ? 3 - wr_cnt / 32 : 1);
          chk("wr_addr", bus_addr, wr_cnt % 32);
          chk("wr_no_oe_start", {bus_oe, bus_start}, 0);
          core_reg[bus_reg_sel][{bus_addr, 3'b000} +: 8] = bus_wdata;
          wr_cnt++;
        end
      end
      if (bus_start) begin
        chk("start_width", prev_start, 1'b0);
        chk("start_bus", {bus_we, bus_oe, bus_reg_sel, bus_addr, bus_wdata}, 0);
        chk("wr_cycles", wr_cnt, (exp_key_q.size() > 0 && exp_key_q[0]) ? 96 : 32);
        if (exp_key_q.size() > 0) void'(exp_key_q.pop_front());
        wr_cnt      = 0;
        core_reg[0] = core_fn(core_reg[1], core_reg[2], core_reg[3]);
        oe_seen     = 1'b0;
        case (rdy_mode)
          0: begin
            bus_ready = 1'b0;
            drop_cyc  = -1;
            rise_cyc  = cyc + int'($urandom_range(1, 20));
          end
          1: begin
            drop_cyc = cyc + int'($urandom_range(2, 6));
            rise_cyc = drop_cyc + int'($urandom_range(1, 4));
          end
          default: begin
            bus_ready = 1'b0;
            drop_cyc  = -1;
            rise_cyc  = -1;
          end
        endcase
        exp_done_cyc = (rise_cyc >= 0) ? rise_cyc + 1 + 32 + RD_LAT : cyc + 1 + TMO;
      end
      if (cyc == drop_cyc) bus_ready = 1'b0;
      if (cyc == rise_cyc) bus_ready = 1'b1;
      if (bus_oe && !oe_seen) begin
        oe_seen = 1'b1;
        chk("oe_first_cycle", cyc, rise_cyc + 1);
      end
      prev_start = bus_start;
    end
  end

  // ---------------- result monitor / scoreboard ----------------
  logic [255:0] held;
  bit prev_valid = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (res_valid) begin
        chk("cmd_ready_busy", cmd_ready, 1'b0);
        chk("done_bus_quiet", {bus_we, bus_oe, bus_start, bus_addr}, 0);
        if (!prev_valid) begin
          held = res_data;
          chk("done_cycle", cyc, exp_done_cyc);
        end else begin
          chk("res_hold", res_data, held);
        end
        if (res_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_err", res_err, e.err);
          end
        end
      end
      prev_valid = res_valid && !res_ready;
    end
  end

  // ---------------- stimulus ----------------
  logic [255:0] ref_n, ref_d;
  bit key_valid = 1'b0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_cmd(input bit key_in, input int mode, input int bp);
    logic [255:0] n, d, c;
    exp_t e;
    bit key;
    bit seen;
    key = key_in || !key_valid;
    n = rand256(); d = rand256(); c = rand256();
    if (key) begin
      ref_n = n; ref_d = d; key_valid = 1'b1;
    end
    e.data = (mode == 2) ? '0 : core_fn(c, ref_d, ref_n);
    e.err  = (mode == 2);
    exp_q.push_back(e);
    exp_key_q.push_back(key);
    rdy_mode = mode;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b1; cmd_load_key = key; cmd_n = n; cmd_d = d; cmd_c = c;
    step();
    cmd_valid = 1'b0; cmd_load_key = $urandom_range(0, 1);
    cmd_n = rand256(); cmd_d = rand256(); cmd_c = rand256();
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    if (!seen) begin
      chk("res_valid_timeout", 1'b0, 1'b1);
      finish_sim();
    end
    for (int i = 0; i < bp; i++) begin
      step();
      cmd_valid = 1'b1; cmd_load_key = $urandom_range(0, 1); cmd_c = rand256();
    end
    step();
    cmd_valid = 1'b0; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic abort_mid_wr_d();
    bit seen;
    exp_key_q.push_back(1'b1);
    rdy_mode = 0;
    @(negedge clk);
    step();
    cmd_valid = 1'b1; cmd_load_key = 1'b1; cmd_n = rand256(); cmd_d = rand256(); cmd_c = rand256();
    step();
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus_we && bus_reg_sel == 2'd2 && bus_addr == 5'd16;
    end
    if (!seen) begin
      chk("wr_d_timeout", 1'b0, 1'b1);
      finish_sim();
    end
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_at_addr17", {bus_we, bus_reg_sel, bus_addr}, {1'b1, 2'd2, 5'd17});
    @(negedge clk);
    chk("abort_bus_zero", {bus_we, bus_oe, bus_start, bus_reg_sel, bus_addr, bus_wdata}, 0);
    chk("abort_cmd_ready", cmd_ready, 1'b1);
    chk("abort_res_valid", res_valid, 1'b0);
    exp_key_q.delete();
    key_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_load_key = 1'b0; res_ready = 1'b0;
    cmd_n = '0; cmd_d = '0; cmd_c = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_bus", {bus_we, bus_oe, bus_start, bus_reg_sel, bus_addr, bus_wdata}, 0);
    chk("reset_res", {res_valid, res_err}, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);

    run_cmd(1'b1, 0, 0);
    run_cmd(1'b0, 0, 10);
    run_cmd(1'b0, 1, 0);
    abort_mid_wr_d();
    run_cmd(1'b1, 0, 0);
    for (int i = 0; i < 8; i++)
      run_cmd(bit'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
`ifdef RSA_MASTER_TIMEOUT_EN
    run_cmd(1'b1, 2, 0);
    run_cmd(1'b0, 0, 0);
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    finish_sim();
  end

  initial begin
    #2_000_000;
    chk("global_timeout", 1'b0, 1'b1);
    finish_sim();
  end

endmodule
